// File: rtl/riscv_retire_monitor.sv
// Commit-side retire monitor: counts retired instructions, reports the last architectural result,
// detects the addi/jalr halt idiom and flags a retire watchdog timeout.
module riscv_retire_monitor #(
    parameter int          CNT_WIDTH  = 32,
    parameter logic [31:0] HALT_INST0 = 32'h00c00093,
    parameter logic [31:0] HALT_INST1 = 32'h00008067,
    parameter int          WDT_CYCLES = 1024
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RET_VALID,
    input  logic [31:0]          RET_INST,
    input  logic                 RET_RF_WE,
    input  logic [31:0]          RET_RF_WD,
    input  logic                 RET_BR_TAKEN,
    input  logic [11:0]          RET_MEM_ADDR,
    output logic [CNT_WIDTH-1:0] NUM_INST,
    output logic [31:0]          OUTPUT_PORT,
    output logic                 HALT,
    output logic                 WDT_ERR
);
    localparam int         WDT_W     = (WDT_CYCLES < 2) ? 1 : $clog2(WDT_CYCLES + 1);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [1:0] {IDLE, ARMED, HALTED} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] num_inst_q, num_inst_d;
    logic [31:0]          out_q, out_d;
    logic                 halt_q, halt_d;
    logic                 wdt_err_q, wdt_err_d;
    logic [WDT_W-1:0]     wdt_cnt_q, wdt_cnt_d;
    logic                 halt_hit, counted, timeout;

    always_comb begin
        halt_hit   = RET_VALID && (state_q == ARMED) && (RET_INST == HALT_INST1);
        counted    = RET_VALID && (state_q != HALTED) && !wdt_err_q && !halt_hit;
        timeout    = (WDT_CYCLES != 0) && (state_q != HALTED) && (wdt_cnt_q == WDT_W'(WDT_CYCLES));

        state_d    = state_q;
        num_inst_d = num_inst_q;
        out_d      = out_q;
        halt_d     = halt_q;
        wdt_err_d  = wdt_err_q;
        wdt_cnt_d  = wdt_cnt_q;

        if (counted) begin
            num_inst_d = num_inst_q + 1'b1;
            if (RET_RF_WE)                    out_d = RET_RF_WD;
            else if (RET_INST[6:0] == OP_BRANCH) out_d = {31'b0, RET_BR_TAKEN};
            else if (RET_INST[6:0] == OP_STORE)  out_d = {20'b0, RET_MEM_ADDR};
        end

        case (state_q)
            IDLE:    if (counted && RET_INST == HALT_INST0) state_d = ARMED;
            ARMED:   if (halt_hit)       state_d = HALTED;
                     else if (RET_VALID) state_d = (RET_INST == HALT_INST0) ? ARMED : IDLE;
            default: state_d = HALTED;
        endcase

        // A completed halt idiom wins over a simultaneous timeout and leaves WDT_ERR clear.
        if (halt_hit) begin
            halt_d = 1'b1;
        end else if (timeout) begin
            state_d   = HALTED;
            halt_d    = 1'b1;
            wdt_err_d = 1'b1;
        end

        if (WDT_CYCLES != 0 && state_q != HALTED) begin
            if (RET_VALID)                            wdt_cnt_d = '0;
            else if (wdt_cnt_q != WDT_W'(WDT_CYCLES)) wdt_cnt_d = wdt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            num_inst_q <= '0;
            out_q      <= '0;
            halt_q     <= 1'b0;
            wdt_err_q  <= 1'b0;
            wdt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            num_inst_q <= num_inst_d;
            out_q      <= out_d;
            halt_q     <= halt_d;
            wdt_err_q  <= wdt_err_d;
            wdt_cnt_q  <= wdt_cnt_d;
        end
    end

    assign NUM_INST    = num_inst_q;
    assign OUTPUT_PORT = out_q;
    assign HALT        = halt_q;
    assign WDT_ERR     = wdt_err_q;
endmodule
